// File: rtl/sequential_2_complement_unit.sv
`default_nettype none
// ============================================================================
// Module   : sequential_2_complement_unit
// Purpose  : Multi-cycle complement unit for the ALU datapath. The operand is
//            processed CHUNK_SIZE bits per clock, with the carry rippling
//            between slices. Supported modes are pass, one's complement,
//            two's complement and absolute value.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous, active-high reset
//            start      - operation request, sampled only while idle
//            mode       - 00 pass, 01 one's compl, 10 two's compl, 11 abs
//            in         - operand, captured on the accepted start edge
//            busy       - high while an operation is running or unconsumed
//            out_valid  - result valid (DONE state)
//            out_ready  - consumer accepts the result
//            out        - result
//            cout       - carry out of the most-significant slice
//            overflow   - result not representable (most-negative operand)
//            zero       - result equals zero
// Revision : 1.0 - initial release
// ============================================================================
module sequential_2_complement_unit #(
    parameter int BUS_SIZE   = 8,   // must be a multiple of CHUNK_SIZE
    parameter int CHUNK_SIZE = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [BUS_SIZE-1:0] in,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BUS_SIZE-1:0] out,
    output logic                cout,
    output logic                overflow,
    output logic                zero
);

    localparam int C_K     = BUS_SIZE / CHUNK_SIZE;
    localparam int C_IDX_W = (C_K > 1) ? $clog2(C_K) : 1;
    localparam logic [C_IDX_W-1:0]  C_LAST_IDX = C_IDX_W'(C_K - 1);
    // Most-negative two's-complement value: 1 followed by zeros.
    localparam logic [BUS_SIZE-1:0] C_MIN_NEG  = BUS_SIZE'(1) << (BUS_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                r_state_q;
    logic [BUS_SIZE-1:0]   r_opnd_q;      // operand, shifted right one slice per cycle
    logic [BUS_SIZE-1:0]   r_res_q;       // result, assembled from the top downwards
    logic                  r_inv_q;
    logic                  r_carry_q;
    logic [C_IDX_W-1:0]    r_idx_q;
    logic                  r_ovf_q;       // captured operand is the most-negative value
    logic [BUS_SIZE-1:0]   r_out_q;
    logic                  r_cout_q;
    logic                  r_overflow_q;
    logic                  r_zero_q;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    state_t                w_state_d;
    logic [BUS_SIZE-1:0]   w_opnd_d;
    logic [BUS_SIZE-1:0]   w_res_d;
    logic                  w_inv_d;
    logic                  w_carry_d;
    logic [C_IDX_W-1:0]    w_idx_d;
    logic                  w_ovf_d;
    logic [BUS_SIZE-1:0]   w_out_d;
    logic                  w_cout_d;
    logic                  w_overflow_d;
    logic                  w_zero_d;

    logic [CHUNK_SIZE-1:0] w_slice;
    logic [CHUNK_SIZE:0]   w_sum;
    logic [BUS_SIZE-1:0]   w_res_next;

    // The active slice is always the bottom of the shifting operand register,
    // so no variable part-select is needed. Each new result slice enters at
    // the top; after K shifts slice 0 lands in the least-significant bits.
    assign w_slice    = r_opnd_q[CHUNK_SIZE-1:0];
    assign w_sum      = {1'b0, w_slice ^ {CHUNK_SIZE{r_inv_q}}} + (CHUNK_SIZE+1)'(r_carry_q);
    assign w_res_next = (r_res_q >> CHUNK_SIZE)
                      | (BUS_SIZE'(w_sum[CHUNK_SIZE-1:0]) << (BUS_SIZE - CHUNK_SIZE));

    always_comb begin
        w_state_d    = r_state_q;
        w_opnd_d     = r_opnd_q;
        w_res_d      = r_res_q;
        w_inv_d      = r_inv_q;
        w_carry_d    = r_carry_q;
        w_idx_d      = r_idx_q;
        w_ovf_d      = r_ovf_q;
        w_out_d      = r_out_q;
        w_cout_d     = r_cout_q;
        w_overflow_d = r_overflow_q;
        w_zero_d     = r_zero_q;

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_state_d = S_RUN;
                    w_opnd_d  = in;
                    w_res_d   = '0;
                    w_idx_d   = '0;
                    w_ovf_d   = mode[1] && (in == C_MIN_NEG);
                    case (mode)
                        2'b00:   begin w_inv_d = 1'b0; w_carry_d = 1'b0; end
                        2'b01:   begin w_inv_d = 1'b1; w_carry_d = 1'b0; end
                        2'b10:   begin w_inv_d = 1'b1; w_carry_d = 1'b1; end
                        // Absolute value negates only when the operand is negative.
                        default: begin w_inv_d = in[BUS_SIZE-1]; w_carry_d = in[BUS_SIZE-1]; end
                    endcase
                end
            end

            S_RUN: begin
                w_opnd_d  = r_opnd_q >> CHUNK_SIZE;
                w_res_d   = w_res_next;
                w_carry_d = w_sum[CHUNK_SIZE];
                w_idx_d   = r_idx_q + 1'b1;
                if (r_idx_q == C_LAST_IDX) begin
                    w_state_d    = S_DONE;
                    w_out_d      = w_res_next;
                    w_cout_d     = w_sum[CHUNK_SIZE];
                    w_overflow_d = r_ovf_q;
                    w_zero_d     = (w_res_next == '0);
                end
            end

            S_DONE: begin
                // start is deliberately not looked at here, even alongside out_ready.
                if (out_ready) begin
                    w_state_d = S_IDLE;
                end
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q    <= S_IDLE;
            r_opnd_q     <= '0;
            r_res_q      <= '0;
            r_inv_q      <= 1'b0;
            r_carry_q    <= 1'b0;
            r_idx_q      <= '0;
            r_ovf_q      <= 1'b0;
            r_out_q      <= '0;
            r_cout_q     <= 1'b0;
            r_overflow_q <= 1'b0;
            r_zero_q     <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_opnd_q     <= w_opnd_d;
            r_res_q      <= w_res_d;
            r_inv_q      <= w_inv_d;
            r_carry_q    <= w_carry_d;
            r_idx_q      <= w_idx_d;
            r_ovf_q      <= w_ovf_d;
            r_out_q      <= w_out_d;
            r_cout_q     <= w_cout_d;
            r_overflow_q <= w_overflow_d;
            r_zero_q     <= w_zero_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (status decoded directly from the state register)
    // ------------------------------------------------------------------------
    assign busy      = (r_state_q != S_IDLE);
    assign out_valid = (r_state_q == S_DONE);
    assign out       = r_out_q;
    assign cout      = r_cout_q;
    assign overflow  = r_overflow_q;
    assign zero      = r_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_sequential_2_complement_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_sequential_2_complement_unit
// Purpose  : Self-checking bench for sequential_2_complement_unit. Three
//            instances: 8/2 (main), 16/4 and 8/8 (single slice).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sequential_2_complement_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 0: BUS_SIZE=8, CHUNK_SIZE=2
    logic        start0 = 1'b0, ready0 = 1'b0;
    logic [1:0]  mode0  = 2'b00;
    logic [7:0]  in0    = 8'h00;
    logic        busy0, valid0, cout0, ovf0, zero0;
    logic [7:0]  out0;
    // Instance 1: BUS_SIZE=16, CHUNK_SIZE=4
    logic        start1 = 1'b0, ready1 = 1'b0;
    logic [1:0]  mode1  = 2'b00;
    logic [15:0] in1    = 16'h0000;
    logic        busy1, valid1, cout1, ovf1, zero1;
    logic [15:0] out1;
    // Instance 2: BUS_SIZE=8, CHUNK_SIZE=8
    logic        start2 = 1'b0, ready2 = 1'b0;
    logic [1:0]  mode2  = 2'b00;
    logic [7:0]  in2    = 8'h00;
    logic        busy2, valid2, cout2, ovf2, zero2;
    logic [7:0]  out2;

    sequential_2_complement_unit #(.BUS_SIZE(8), .CHUNK_SIZE(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode0), .in(in0),
        .busy(busy0), .out_valid(valid0), .out_ready(ready0), .out(out0),
        .cout(cout0), .overflow(ovf0), .zero(zero0));

    sequential_2_complement_unit #(.BUS_SIZE(16), .CHUNK_SIZE(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .in(in1),
        .busy(busy1), .out_valid(valid1), .out_ready(ready1), .out(out1),
        .cout(cout1), .overflow(ovf1), .zero(zero1));

    sequential_2_complement_unit #(.BUS_SIZE(8), .CHUNK_SIZE(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode2), .in(in2),
        .busy(busy2), .out_valid(valid2), .out_ready(ready2), .out(out2),
        .cout(cout2), .overflow(ovf2), .zero(zero2));

    typedef struct packed {
        logic [15:0] out;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          lat;
    } res_t;

    res_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: whole-word arithmetic, independent of slicing.
    function automatic res_t model(input int bw, input logic [15:0] x_in, input logic [1:0] m);
        logic [15:0] mask, x, minneg;
        logic [16:0] full;
        logic        inv, c0;
        res_t        r;
        mask   = (bw == 16) ? 16'hFFFF : 16'h00FF;
        minneg = (bw == 16) ? 16'h8000 : 16'h0080;
        x      = x_in & mask;
        case (m)
            2'b00:   begin inv = 1'b0; c0 = 1'b0; end
            2'b01:   begin inv = 1'b1; c0 = 1'b0; end
            2'b10:   begin inv = 1'b1; c0 = 1'b1; end
            default: begin inv = (bw == 16) ? x[15] : x[7]; c0 = inv; end
        endcase
        full   = {1'b0, (inv ? ~x : x) & mask} + {16'h0, c0};
        r.out  = full[15:0] & mask;
        r.cout = (bw == 16) ? full[16] : full[8];
        r.ovf  = m[1] && (x == minneg);
        r.zero = (r.out == 16'h0);
        r.lat  = (bw == 16) ? 4 : 0;
        return r;
    endfunction

    function automatic int k_of(input int inst);
        return (inst == 2) ? 1 : 4;
    endfunction

    function automatic int bw_of(input int inst);
        return (inst == 1) ? 16 : 8;
    endfunction

    task automatic drive(input int inst, input logic s, input logic [15:0] x,
                         input logic [1:0] m, input logic r);
        case (inst)
            0:       begin start0 = s; in0 = x[7:0]; mode0 = m; ready0 = r; end
            1:       begin start1 = s; in1 = x;      mode1 = m; ready1 = r; end
            default: begin start2 = s; in2 = x[7:0]; mode2 = m; ready2 = r; end
        endcase
    endtask

    function automatic logic valid_of(input int inst);
        case (inst)
            0:       return valid0;
            1:       return valid1;
            default: return valid2;
        endcase
    endfunction

    function automatic res_t sample(input int inst);
        res_t r;
        case (inst)
            0:       r = '{out: {8'h0, out0}, cout: cout0, ovf: ovf0, zero: zero0, lat: 0};
            1:       r = '{out: out1,         cout: cout1, ovf: ovf1, zero: zero1, lat: 0};
            default: r = '{out: {8'h0, out2}, cout: cout2, ovf: ovf2, zero: zero2, lat: 0};
        endcase
        return r;
    endfunction

    // Issue one operation from IDLE, push its expectation, wait (bounded)
    // for out_valid and pop. Leaves the DUT in DONE. lat = -1 on timeout.
    task automatic issue(input int inst, input logic [15:0] x, input logic [1:0] m,
                         output res_t obs, output res_t exp_r);
        res_t e;
        int   n;
        e     = model(bw_of(inst), x, m);
        e.lat = k_of(inst);
        sb.push_back(e);
        drive(inst, 1'b1, x, m, 1'b0);
        @(posedge clk); #1;
        // Scramble the inputs after capture; the result must not follow them.
        drive(inst, 1'b0, ~x, ~m, 1'b0);
        n = 0;
        while (!valid_of(inst) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        obs     = sample(inst);
        obs.lat = valid_of(inst) ? n : -1;
        exp_r   = sb.pop_front();
    endtask

    task automatic release_out(input int inst);
        drive(inst, 1'b0, 16'h0, 2'b00, 1'b1);
        @(posedge clk); #1;
        drive(inst, 1'b0, 16'h0, 2'b00, 1'b0);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset;
        res_t obs, e;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy0, valid0, out0, cout0, ovf0, zero0} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_state0: got busy=%b valid=%b out=%h cout=%b ovf=%b zero=%b, required all 0",
                     busy0, valid0, out0, cout0, ovf0, zero0);
        end
        n_checks++;
        if ({busy1, valid1, out1, cout1, ovf1, zero1, busy2, valid2, out2, cout2, ovf2, zero2} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_state12: got out1=%h out2=%h busy1=%b busy2=%b, required all 0",
                     out1, out2, busy1, busy2);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Leave a non-zero result behind so the reset clearing is visible.
        issue(0, 16'h3C, 2'b01, obs, e);
        release_out(0);

        // Reset two edges into an operation.
        drive(0, 1'b1, 16'h05, 2'b10, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h00, 2'b00, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy0, valid0, out0, cout0, ovf0, zero0} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_midrun: got busy=%b valid=%b out=%h cout=%b ovf=%b zero=%b, required all 0",
                     busy0, valid0, out0, cout0, ovf0, zero0);
        end
        #2;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (valid0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_partial: got valid=%b busy=%b, required 0 0", valid0, busy0);
        end

        issue(0, 16'h05, 2'b10, obs, e);
        n_checks++;
        if (obs.out !== 16'h00FB || obs.lat !== 4) begin
            n_fail++;
            $display("FAIL reset_restart: got out=%h lat=%0d, required out=00fb lat=4", obs.out, obs.lat);
        end
        release_out(0);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_modes;
        logic [7:0] t_in  [8] = '{8'h3C, 8'h05, 8'h37, 8'hF6, 8'h37, 8'h00, 8'h80, 8'h80};
        logic [1:0] t_md  [8] = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b11, 2'b10, 2'b10, 2'b11};
        logic [7:0] t_out [8] = '{8'hC3, 8'hFB, 8'h37, 8'h0A, 8'h37, 8'h00, 8'h80, 8'h80};
        logic       t_cy  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       t_ov  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       t_z   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        res_t obs, e;
        for (int i = 0; i < 8; i++) begin
            issue(0, {8'h0, t_in[i]}, t_md[i], obs, e);
            n_checks++;
            if (obs.out !== {8'h0, t_out[i]} || obs.cout !== t_cy[i] ||
                obs.ovf !== t_ov[i] || obs.zero !== t_z[i]) begin
                n_fail++;
                $display("FAIL mode_table[%0d] in=%h mode=%b: got out=%h cout=%b ovf=%b zero=%b, required out=%h cout=%b ovf=%b zero=%b",
                         i, t_in[i], t_md[i], obs.out[7:0], obs.cout, obs.ovf, obs.zero,
                         t_out[i], t_cy[i], t_ov[i], t_z[i]);
            end
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL mode_sb[%0d]: got out=%h cout=%b ovf=%b zero=%b lat=%0d, required out=%h cout=%b ovf=%b zero=%b lat=%0d",
                         i, obs.out, obs.cout, obs.ovf, obs.zero, obs.lat, e.out, e.cout, e.ovf, e.zero, e.lat);
            end
            release_out(0);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_handshake;
        res_t       e;
        logic [7:0] snap;
        int         n;
        e     = model(8, 16'h3C, 2'b01);
        e.lat = 4;
        sb.push_back(e);
        drive(0, 1'b1, 16'h3C, 2'b01, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h00, 2'b00, 1'b0);
        @(posedge clk); #1;
        // start pulse while running must be ignored
        drive(0, 1'b1, 16'h11, 2'b10, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h00, 2'b00, 1'b0);
        n = 2;
        while (!valid0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        n_checks++;
        if (valid0 !== 1'b1 || n !== e.lat || {8'h0, out0} !== e.out) begin
            n_fail++;
            $display("FAIL hs_run_start_ignored: got valid=%b lat=%0d out=%h, required valid=1 lat=%0d out=%h",
                     valid0, n, out0, e.lat, e.out[7:0]);
        end
        snap = out0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (valid0 !== 1'b1 || out0 !== snap) begin
                n_fail++;
                $display("FAIL hs_hold[%0d]: got valid=%b out=%h, required valid=1 out=%h", c, valid0, out0, snap);
            end
        end
        // start together with out_ready in DONE must be ignored
        drive(0, 1'b1, 16'h05, 2'b10, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h00, 2'b00, 1'b0);
        n_checks++;
        if (valid0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_release: got valid=%b busy=%b, required 0 0", valid0, busy0);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy0 !== 1'b0 || out0 !== 8'hC3) begin
            n_fail++;
            $display("FAIL hs_idle_hold: got busy=%b out=%h, required busy=0 out=c3", busy0, out0);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_param_sweep;
        res_t        obs, e;
        logic [15:0] x;
        logic [1:0]  m;
        int          errs;
        for (int inst = 1; inst <= 2; inst++) begin
            errs = 0;
            for (int i = 0; i < 30; i++) begin
                case (i)
                    0:       begin x = (inst == 1) ? 16'h8000 : 16'h0080; m = 2'b11; end
                    1:       begin x = 16'h0000; m = 2'b10; end
                    2:       begin x = (inst == 1) ? 16'h8000 : 16'h0080; m = 2'b10; end
                    default: begin x = 16'($urandom); m = 2'($urandom_range(0, 3)); end
                endcase
                if (inst == 2) x = x & 16'h00FF;
                issue(inst, x, m, obs, e);
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL sweep_inst%0d[%0d] in=%h mode=%b: got out=%h cout=%b ovf=%b zero=%b lat=%0d, required out=%h cout=%b ovf=%b zero=%b lat=%0d",
                             inst, i, x, m, obs.out, obs.cout, obs.ovf, obs.zero, obs.lat,
                             e.out, e.cout, e.ovf, e.zero, e.lat);
                end
                release_out(inst);
            end
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_handshake();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
